param_core: RTL and testbench

- Parametrised successor to the team's single-width compute core.
- Holds a local data memory, a 4-entry register file and a small ALU, and executes one 15-bit instruction at a time under a valid/ready handshake, with a done pulse per instruction.
- Adds generic width and depth, Z/C flags, conditional execution, split host read/write buses and a stall signal, and a dedicated read-only buffer port for the display path.
- Sits between the host/controller and the frame-buffer reader.

---
 rtl/param_core.sv | 197 +++++++++++++++++++
 tb/tb_param_core.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_core.sv
// Parametrised compute core: local data memory, 4-entry register file, Z/C flags,
// conditional execution, host read/write port and an independent buffer read port.
//
// state | meaning
// IDLE  | ready for an instruction and for host accesses
// EXEC  | evaluate condition, commit ALU/LDI result or STORE, or issue LOAD read
// MEMWB | write LOAD data into the destination register
module param_core #(
    parameter int DATA_WIDTH        = 16,
    parameter int ADDRESS_WIDTH     = 16,
    parameter int MEM_DEPTH         = 256,
    parameter int INSTRUCTION_WIDTH = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [INSTRUCTION_WIDTH-1:0] instr,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    output logic                         done,
    output logic                         illegal,
    input  logic                         host_cs,
    input  logic                         host_we,
    input  logic [ADDRESS_WIDTH-1:0]     host_addr,
    input  logic [DATA_WIDTH-1:0]        host_wdata,
    output logic [DATA_WIDTH-1:0]        host_rdata,
    output logic                         host_ready,
    input  logic [ADDRESS_WIDTH-1:0]     buf_addr,
    output logic [DATA_WIDTH-1:0]        buf_data,
    input  logic [1:0]                   dbg_sel,
    output logic [DATA_WIDTH-1:0]        dbg_data,
    output logic [1:0]                   flags
);

    localparam int MAW = $clog2(MEM_DEPTH);

    localparam logic [3:0] OP_MOV   = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_NOT   = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_SHR   = 4'd9;
    localparam logic [3:0] OP_LDI   = 4'd10;
    localparam logic [3:0] OP_LOAD  = 4'd11;
    localparam logic [3:0] OP_STORE = 4'd12;

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MEMWB = 2'd2} state_t;

    state_t                         state, state_nxt;
    logic [INSTRUCTION_WIDTH-1:0]   instr_q;
    logic [DATA_WIDTH-1:0]          regs [4];
    logic [DATA_WIDTH-1:0]          mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]          load_q;
    logic                           z_q, c_q;

    logic                           cond;
    logic [3:0]                     opcode, imm4;
    logic [1:0]                     rd, rs1, rs2;
    logic [DATA_WIDTH-1:0]          s1v, s2v;
    logic [MAW-1:0]                 s1_idx, host_idx, buf_idx;

    logic [DATA_WIDTH:0]            sum, diff;
    logic [DATA_WIDTH-1:0]          alu_res, reg_wdata;
    logic                           alu_c, alu_wr, shift_big;
    logic                           accept, done_nxt, ill_nxt, reg_we, flag_we, store_we;
    logic                           host_acc;
    logic                           unused_bits;

    assign cond   = instr_q[14];
    assign opcode = instr_q[13:10];
    assign imm4   = instr_q[9:6];
    assign rd     = instr_q[5:4];
    assign rs1    = instr_q[3:2];
    assign rs2    = instr_q[1:0];

    assign s1v      = regs[rs1];
    assign s2v      = regs[rs2];
    assign s1_idx   = s1v[MAW-1:0];
    assign host_idx = host_addr[MAW-1:0];
    assign buf_idx  = buf_addr[MAW-1:0];
    assign unused_bits = ^{host_addr[ADDRESS_WIDTH-1:MAW], buf_addr[ADDRESS_WIDTH-1:MAW]};

    assign instr_ready = (state == IDLE) & rst_n;
    assign host_ready  = (state == IDLE) & rst_n;
    assign host_acc    = host_cs & host_ready;
    assign dbg_data    = regs[dbg_sel];
    assign flags       = {z_q, c_q};

    assign sum       = {1'b0, s1v} + {1'b0, s2v};
    assign diff      = {1'b0, s1v} - {1'b0, s2v};
    assign shift_big = s2v >= DATA_WIDTH'(DATA_WIDTH);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_wr  = 1'b1;
        case (opcode)
            OP_MOV: alu_res = s1v;
            OP_ADD: begin alu_res = sum[DATA_WIDTH-1:0];  alu_c = sum[DATA_WIDTH];  end
            OP_SUB: begin alu_res = diff[DATA_WIDTH-1:0]; alu_c = diff[DATA_WIDTH]; end
            OP_AND: alu_res = s1v & s2v;
            OP_OR:  alu_res = s1v | s2v;
            OP_XOR: alu_res = s1v ^ s2v;
            OP_NOT: alu_res = ~s1v;
            OP_SHL: alu_res = shift_big ? '0 : s1v << s2v;
            OP_SHR: alu_res = shift_big ? '0 : s1v >> s2v;
            OP_LDI: alu_res = {{(DATA_WIDTH-4){1'b0}}, imm4};
            default: alu_wr = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done_nxt  = 1'b0;
        ill_nxt   = 1'b0;
        reg_we    = 1'b0;
        reg_wdata = alu_res;
        flag_we   = 1'b0;
        store_we  = 1'b0;
        case (state)
            IDLE: begin
                if (instr_valid) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
                // A false condition retires like a NOP: done only, no writes
                if (!cond || z_q) begin
                    if (opcode == OP_LOAD) begin
                        state_nxt = MEMWB;
                        done_nxt  = 1'b0;
                    end else if (opcode == OP_STORE) begin
                        store_we = 1'b1;
                    end else if (opcode > OP_STORE) begin
                        ill_nxt = 1'b1;
                    end else if (alu_wr) begin
                        reg_we  = 1'b1;
                        flag_we = 1'b1;
                    end
                end
            end
            MEMWB: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
                reg_we    = 1'b1;
                reg_wdata = load_q;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            instr_q <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            state   <= state_nxt;
            done    <= done_nxt;
            illegal <= ill_nxt;
            if (accept) instr_q <= instr;
            if (reg_we) regs[rd] <= reg_wdata;
            if (flag_we) begin
                z_q <= (alu_res == '0);
                c_q <= alu_c;
            end
        end
    end

    // Host writes only happen in IDLE and STORE only in EXEC, so the write port never collides
    always_ff @(posedge clk) begin
        if (host_acc && host_we) mem[host_idx] <= host_wdata;
        else if (store_we)       mem[s1_idx]   <= s2v;
        load_q <= mem[s1_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_rdata <= '0;
            buf_data   <= '0;
        end else begin
            if (host_acc && !host_we) host_rdata <= mem[host_idx];
            buf_data <= mem[buf_idx];
        end
    end

endmodule

// File: tb/tb_param_core.sv
// Directed bench for param_core: table of instructions with hand-computed results,
// plus hand-written host, buffer and reset sequences.
module tb_param_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] instr;
    logic        instr_valid, instr_ready, done, illegal;
    logic        host_cs, host_we, host_ready;
    logic [15:0] host_addr, host_wdata, host_rdata;
    logic [15:0] buf_addr, buf_data, dbg_data;
    logic [1:0]  dbg_sel, flags;

    int n_cmp = 0;
    int n_err = 0;

    param_core dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .done(done), .illegal(illegal),
        .host_cs(host_cs), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ready(host_ready),
        .buf_addr(buf_addr), .buf_data(buf_data), .dbg_sel(dbg_sel),
        .dbg_data(dbg_data), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] ins;
        int          lat;
        logic [1:0]  sel;
        logic [15:0] val;
        logic [1:0]  fl;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [14:0] enc(input logic c, input logic [3:0] op, input logic [3:0] imm,
                                        input logic [1:0] d, input logic [1:0] s1, input logic [1:0] s2);
        return {c, op, imm, d, s1, s2};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [15:0] a, input logic [15:0] d);
        chk("host_ready_wr", 32'(host_ready), 32'd1);
        host_cs = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        @(negedge clk);
        host_cs = 1'b0; host_we = 1'b0;
    endtask

    task automatic host_read(input logic [15:0] a, input logic [15:0] exp);
        chk("host_ready_rd", 32'(host_ready), 32'd1);
        host_cs = 1'b1; host_we = 1'b0; host_addr = a;
        @(negedge clk);
        host_cs = 1'b0;
        chk("host_rdata", 32'(host_rdata), 32'(exp));
    endtask

    task automatic check_regs(input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] ev [4];
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            chk($sformatf("reg_r%0d", i), 32'(dbg_data), 32'(ev[i]));
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge where done is seen
    task automatic run_instr(input string name, input logic [14:0] ins, input int lat,
                             input logic [1:0] sel, input logic [15:0] val, input logic [1:0] fl,
                             input logic ill, input logic chk_buf, input logic [15:0] buf_exp);
        int n;
        dbg_sel = sel;
        chk({name, "_ready"}, 32'(instr_ready), 32'd1);
        instr = ins; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 8) begin
            chk({name, "_busy_host_ready"}, 32'(host_ready), 32'd0);
            chk({name, "_early_illegal"}, 32'(illegal), 32'd0);
            if (chk_buf) chk({name, "_buf"}, 32'(buf_data), 32'(buf_exp));
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'(lat));
        chk({name, "_result"}, 32'(dbg_data), 32'(val));
        chk({name, "_flags"}, 32'(flags), 32'(fl));
        chk({name, "_illegal"}, 32'(illegal), 32'(ill));
        if (chk_buf) chk({name, "_buf"}, 32'(buf_data), 32'(buf_exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; instr = '0; instr_valid = 1'b0;
        host_cs = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        buf_addr = '0; dbg_sel = '0;

        // {Z,C} expectations in the fl column
        vecs.push_back('{enc(0, 10, 11, 0, 0, 0), 2, 2'd0, 16'h000B, 2'b00, 1'b0}); // LDI r0,B
        vecs.push_back('{enc(0, 10,  5, 1, 0, 0), 2, 2'd1, 16'h0005, 2'b00, 1'b0}); // LDI r1,5
        vecs.push_back('{enc(0,  2,  0, 2, 0, 1), 2, 2'd2, 16'h0010, 2'b00, 1'b0}); // ADD r2,r0,r1
        vecs.push_back('{enc(0,  3,  0, 3, 1, 0), 2, 2'd3, 16'hFFFA, 2'b01, 1'b0}); // SUB r3,r1,r0
        vecs.push_back('{enc(1, 10, 15, 1, 0, 0), 2, 2'd1, 16'h0005, 2'b01, 1'b0}); // ?LDI skipped
        vecs.push_back('{enc(0,  3,  0, 3, 0, 0), 2, 2'd3, 16'h0000, 2'b10, 1'b0}); // SUB r3,r0,r0
        vecs.push_back('{enc(1, 10, 15, 1, 0, 0), 2, 2'd1, 16'h000F, 2'b00, 1'b0}); // ?LDI taken
        vecs.push_back('{enc(0, 10,  5, 1, 0, 0), 2, 2'd1, 16'h0005, 2'b00, 1'b0}); // LDI r1,5
        vecs.push_back('{enc(0, 12,  0, 0, 1, 0), 2, 2'd0, 16'h000B, 2'b00, 1'b0}); // STORE [r1]=r0
        vecs.push_back('{enc(0, 11,  0, 3, 1, 0), 3, 2'd3, 16'h000B, 2'b00, 1'b0}); // LOAD r3,[r1]
        vecs.push_back('{enc(0,  3,  0, 2, 1, 0), 2, 2'd2, 16'hFFFA, 2'b01, 1'b0}); // SUB r2,r1,r0
        vecs.push_back('{enc(0,  4,  0, 2, 0, 1), 2, 2'd2, 16'h0001, 2'b00, 1'b0}); // AND clears C
        vecs.push_back('{enc(0,  5,  0, 2, 0, 1), 2, 2'd2, 16'h000F, 2'b00, 1'b0}); // OR
        vecs.push_back('{enc(0,  6,  0, 2, 0, 1), 2, 2'd2, 16'h000E, 2'b00, 1'b0}); // XOR
        vecs.push_back('{enc(0,  7,  0, 2, 0, 0), 2, 2'd2, 16'hFFF4, 2'b00, 1'b0}); // NOT r2,r0
        vecs.push_back('{enc(0,  8,  0, 2, 0, 1), 2, 2'd2, 16'h0160, 2'b00, 1'b0}); // SHL r2,r0,r1
        vecs.push_back('{enc(0,  9,  0, 2, 2, 1), 2, 2'd2, 16'h000B, 2'b00, 1'b0}); // SHR r2,r2,r1
        vecs.push_back('{enc(0, 10,  8, 3, 0, 0), 2, 2'd3, 16'h0008, 2'b00, 1'b0}); // LDI r3,8
        vecs.push_back('{enc(0,  2,  0, 3, 3, 3), 2, 2'd3, 16'h0010, 2'b00, 1'b0}); // ADD r3,r3,r3
        vecs.push_back('{enc(0,  8,  0, 2, 0, 3), 2, 2'd2, 16'h0000, 2'b10, 1'b0}); // SHL by 16
        vecs.push_back('{enc(0,  1,  0, 2, 1, 0), 2, 2'd2, 16'h0005, 2'b00, 1'b0}); // MOV r2,r1
        vecs.push_back('{enc(0,  9,  0, 2, 0, 3), 2, 2'd2, 16'h0000, 2'b10, 1'b0}); // SHR by 16
        vecs.push_back('{enc(0,  7,  0, 2, 2, 0), 2, 2'd2, 16'hFFFF, 2'b00, 1'b0}); // NOT r2,r2
        vecs.push_back('{enc(0,  2,  0, 2, 2, 1), 2, 2'd2, 16'h0004, 2'b01, 1'b0}); // ADD carry
        vecs.push_back('{enc(0,  0,  0, 2, 0, 0), 2, 2'd2, 16'h0004, 2'b01, 1'b0}); // NOP
        vecs.push_back('{enc(0, 14,  0, 2, 0, 0), 2, 2'd2, 16'h0004, 2'b01, 1'b1}); // reserved
        vecs.push_back('{enc(0, 10, 15, 3, 0, 0), 2, 2'd3, 16'h000F, 2'b00, 1'b0}); // LDI r3,15
        vecs.push_back('{enc(0,  8,  0, 2, 0, 3), 2, 2'd2, 16'h8000, 2'b00, 1'b0}); // SHL by 15

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_instr_ready", 32'(instr_ready), 32'd0);
        chk("rst_host_ready", 32'(host_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_instr_ready", 32'(instr_ready), 32'd1);
        chk("rel_host_ready", 32'(host_ready), 32'd1);
        chk("rel_flags", 32'(flags), 32'd0);
        chk("rel_host_rdata", 32'(host_rdata), 32'd0);
        chk("rel_buf_data", 32'(buf_data), 32'd0);
        check_regs(16'h0, 16'h0, 16'h0, 16'h0);
        @(negedge clk);

        // Host write then read back
        host_write(16'h0000, 16'h4000);
        host_write(16'h0001, 16'h01C0);
        host_read(16'h0000, 16'h4000);
        host_read(16'h0001, 16'h01C0);
        @(negedge clk);
        chk("host_rdata_hold", 32'(host_rdata), 32'h01C0);

        // Instruction table, issued back to back
        foreach (vecs[i])
            run_instr($sformatf("vec%0d", i), vecs[i].ins, vecs[i].lat, vecs[i].sel,
                      vecs[i].val, vecs[i].fl, vecs[i].ill, 1'b0, 16'h0);
        @(negedge clk);
        chk("done_single_pulse", 32'(done), 32'd0);
        chk("illegal_single_pulse", 32'(illegal), 32'd0);
        check_regs(16'h000B, 16'h0005, 16'h8000, 16'h000F);

        // Address aliasing: 0x0105 maps onto word 5
        host_read(16'h0105, 16'h000B);

        // Buffer port held on address 1 across a LOAD
        buf_addr = 16'h0001;
        @(negedge clk);
        chk("buf_first", 32'(buf_data), 32'h01C0);
        run_instr("load_buf", enc(0, 11, 0, 2, 1, 0), 3, 2'd2, 16'h000B, 2'b00, 1'b0,
                  1'b1, 16'h01C0);

        // Buffer read of a word being written returns the old value
        host_write(16'h0007, 16'h1111);
        buf_addr = 16'h0007;
        @(negedge clk);
        chk("buf_pre", 32'(buf_data), 32'h1111);
        host_write(16'h0007, 16'h2222);
        chk("buf_old_data", 32'(buf_data), 32'h1111);
        @(negedge clk);
        chk("buf_new_data", 32'(buf_data), 32'h2222);

        // Reset during MEMWB of a LOAD
        dbg_sel = 2'd2;
        instr = enc(0, 11, 0, 2, 1, 0); instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("memwb_busy", 32'(host_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_instr_ready", 32'(instr_ready), 32'd0);
        chk("midrst_flags", 32'(flags), 32'd0);
        check_regs(16'h0, 16'h0, 16'h0, 16'h0);
        @(negedge clk);
        chk("midrst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("midrst_rel_ready", 32'(instr_ready), 32'd1);
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(done), 32'd0);
            chk("midrst_no_illegal", 32'(illegal), 32'd0);
        end
        check_regs(16'h0, 16'h0, 16'h0, 16'h0);
        host_read(16'h0000, 16'h4000);
        host_read(16'h0001, 16'h01C0);
        host_read(16'h0005, 16'h000B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
